front_panel_ctrl: RTL

- Console-side responder for the front-panel switch/button load protocol.
- While the CPU is stopped (run low), it turns button presses into PC loads, AC loads and memory deposits.
  - Button presses: btnl = Load PC, btnd = Deposit, btnr = Load AC.
  - Deposits are sequenced as write handshakes on the memory bus, and the load address auto-increments.
- Sits in Top between the board buttons/switches and the memory bus arbiter, alongside the CPU FSM.

---
 rtl/front_panel_ctrl_pkg.sv | 26 ++
 rtl/front_panel_ctrl_button_cond.sv | 50 +++++
 rtl/front_panel_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/front_panel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : front_panel_ctrl_pkg
// Purpose : Shared word type and front-panel FSM state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package front_panel_ctrl_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    FP_IDLE   = 3'd0,
    FP_LOADPC = 3'd1,
    FP_LOADAC = 3'd2,
    FP_WRITE  = 3'd3,
    FP_INC    = 3'd4
  } fp_state_t;

  function automatic word_t word_inc(input word_t w);
    return w + word_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/front_panel_ctrl_button_cond.sv
`default_nettype none
// ============================================================================
// Module  : fp_button_cond
// Purpose : Button synchroniser, stable-high debounce counter, press pulse.
// Rev     : 1.0  initial release
// ============================================================================
module fp_button_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [7:0] c_DEB = 8'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_cnt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Saturation at the threshold keeps a held button from re-firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_sync) begin
      r_cnt <= '0;
    end else if (r_cnt != c_DEB) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_press = w_sync && (r_cnt == (c_DEB - 8'd1));

endmodule
`default_nettype wire

// File: rtl/front_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : front_panel_ctrl
// Purpose : Front-panel Load PC / Load AC / Deposit sequencer for stopped CPU.
// Rev     : 1.0  initial release
// ============================================================================
module front_panel_ctrl
  import front_panel_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  run,
  input  word_t sw_data,
  input  logic  btn_load_pc,
  input  logic  btn_deposit,
  input  logic  btn_load_ac,
  input  logic  mem_finished,
  output logic  fp_write_enable,
  output word_t fp_address,
  output word_t fp_write_data,
  output logic  fp_load_pc,
  output logic  fp_load_ac,
  output word_t fp_value,
  output word_t load_addr,
  output logic  busy
);

  fp_state_t r_state;
  fp_state_t w_next;
  logic      w_press_pc;
  logic      w_press_dep;
  logic      w_press_ac;
  logic      w_ev_pc;
  logic      w_ev_dep;
  logic      w_ev_ac;
  word_t     r_fp_value;
  word_t     r_load_addr;
  word_t     r_fp_address;
  word_t     r_fp_write_data;

  fp_button_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_pc (
    .clk(clk), .rst(reset), .i_btn(btn_load_pc), .o_press(w_press_pc)
  );
  fp_button_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_dep (
    .clk(clk), .rst(reset), .i_btn(btn_deposit), .o_press(w_press_dep)
  );
  fp_button_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_ac (
    .clk(clk), .rst(reset), .i_btn(btn_load_ac), .o_press(w_press_ac)
  );

  // Events only count in idle with the CPU stopped; priority pc > deposit > ac.
  assign w_ev_pc  = w_press_pc  && !run && (r_state == FP_IDLE);
  assign w_ev_dep = w_press_dep && !run && (r_state == FP_IDLE) && !w_press_pc;
  assign w_ev_ac  = w_press_ac  && !run && (r_state == FP_IDLE) && !w_press_pc && !w_press_dep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FP_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    fp_write_enable = 1'b0;
    fp_load_pc      = 1'b0;
    fp_load_ac      = 1'b0;
    busy            = 1'b1;
    case (r_state)
      FP_IDLE: begin
        busy = 1'b0;
        if (w_ev_pc) begin
          w_next = FP_LOADPC;
        end else if (w_ev_dep) begin
          w_next = FP_WRITE;
        end else if (w_ev_ac) begin
          w_next = FP_LOADAC;
        end
      end
      FP_LOADPC: begin
        fp_load_pc = 1'b1;
        w_next     = FP_IDLE;
      end
      FP_LOADAC: begin
        fp_load_ac = 1'b1;
        w_next     = FP_IDLE;
      end
      FP_WRITE: begin
        fp_write_enable = 1'b1;
        if (mem_finished) begin
          w_next = FP_INC;
        end
      end
      FP_INC: begin
        w_next = FP_IDLE;
      end
      default: begin
        w_next = FP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fp_value      <= '0;
      r_load_addr     <= '0;
      r_fp_address    <= '0;
      r_fp_write_data <= '0;
    end else begin
      if (w_ev_pc) begin
        r_fp_value  <= sw_data;
        r_load_addr <= sw_data;
      end
      if (w_ev_dep) begin
        r_fp_address    <= r_load_addr;
        r_fp_write_data <= sw_data;
      end
      if (w_ev_ac) begin
        r_fp_value <= sw_data;
      end
      if (r_state == FP_INC) begin
        r_load_addr <= word_inc(r_load_addr);
      end
    end
  end

  assign fp_value      = r_fp_value;
  assign load_addr     = r_load_addr;
  assign fp_address    = r_fp_address;
  assign fp_write_data = r_fp_write_data;

endmodule
`default_nettype wire
